// File: rtl/gate_response_checker_if.sv
// Handshake and stimulus/response bundle between the checker and its bench/harness.
interface gate_response_checker_if #(
   parameter int unsigned ERRW = 3
);
   logic            start;
   logic            dut_a;
   logic            dut_b;
   logic            dut_y;
   logic            busy;
   logic            done;
   logic            pass;
   logic [ERRW-1:0] err_cnt;
   logic [1:0]      first_fail;

   // Checker side: drives stimulus and status, receives start and the DUT response.
   modport master (
      input  start,
      input  dut_y,
      output dut_a,
      output dut_b,
      output busy,
      output done,
      output pass,
      output err_cnt,
      output first_fail
   );

   // Requester side: issues start, supplies the DUT response, observes status.
   modport slave (
      output start,
      output dut_y,
      input  dut_a,
      input  dut_b,
      input  busy,
      input  done,
      input  pass,
      input  err_cnt,
      input  first_fail
   );
endinterface

// File: rtl/gate_response_checker.sv
// Response sequencer for 2-input gates: sweeps {a,b}, waits SETTLE cycles per
// vector, compares dut_y against TRUTH, and reports errors and the first failure.
module gate_response_checker #(
   parameter logic [3:0]  TRUTH  = 4'b0001,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned LOOPS  = 1,
   parameter int unsigned ERRW   = 3
) (
   input logic                    clk,
   input logic                    rst,
   gate_response_checker_if.master bus
);

   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [LW-1:0]   LOOP_LAST   = LW'(LOOPS - 1);
   localparam logic [ERRW-1:0] ERR_MAX     = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      vec_q, vec_d;
   logic [LW-1:0]   loop_q, loop_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [ERRW-1:0] err_q, err_d;
   logic            pass_q, pass_d;
   logic [1:0]      ff_q, ff_d;
   logic            ff_flag_q, ff_flag_d;

   logic            mismatch;
   logic            last_vec;

   assign mismatch = (bus.dut_y != TRUTH[vec_q]);
   assign last_vec = (vec_q == 2'b11) && (loop_q == LOOP_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.start) state_d = S_WAIT;
         S_WAIT:   if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
         S_SAMPLE: state_d = last_vec ? S_DONE : S_WAIT;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         S_WAIT, S_SAMPLE: bus.busy = 1'b1;
         S_DONE:           bus.done = 1'b1;
         default:          ;
      endcase
   end

   // Datapath next values: vector/loop/settle counters and result tracking.
   always_comb begin
      vec_d     = vec_q;
      loop_d    = loop_q;
      settle_d  = settle_q;
      err_d     = err_q;
      pass_d    = pass_q;
      ff_d      = ff_q;
      ff_flag_d = ff_flag_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               vec_d     = '0;
               loop_d    = '0;
               settle_d  = '0;
               err_d     = '0;
               pass_d    = 1'b0;
               ff_d      = '0;
               ff_flag_d = 1'b0;
            end
         end
         S_WAIT: begin
            // Counter is cleared on the exit edge so the next vector starts from 0.
            settle_d = (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
         end
         S_SAMPLE: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) err_d = err_q + 1'b1;
               if (!ff_flag_q) begin
                  ff_d      = vec_q;
                  ff_flag_d = 1'b1;
               end
            end
            if (vec_q != 2'b11) begin
               vec_d = vec_q + 2'b01;
            end else if (loop_q != LOOP_LAST) begin
               vec_d  = '0;
               loop_d = loop_q + 1'b1;
            end
         end
         S_DONE: begin
            pass_d = (err_q == '0);
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q     <= '0;
         loop_q    <= '0;
         settle_q  <= '0;
         err_q     <= '0;
         pass_q    <= 1'b0;
         ff_q      <= '0;
         ff_flag_q <= 1'b0;
      end else begin
         vec_q     <= vec_d;
         loop_q    <= loop_d;
         settle_q  <= settle_d;
         err_q     <= err_d;
         pass_q    <= pass_d;
         ff_q      <= ff_d;
         ff_flag_q <= ff_flag_d;
      end
   end

   // The stimulus bits follow the vector index, holding the last vector when idle.
   always_comb begin
      bus.dut_a      = vec_q[1];
      bus.dut_b      = vec_q[0];
      bus.err_cnt    = err_q;
      bus.pass       = pass_q;
      bus.first_fail = ff_q;
   end

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode0 = 0;
   int   mode1 = 3;
   int   n_total = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   gate_response_checker_if #(.ERRW(3)) if0 ();
   gate_response_checker_if #(.ERRW(2)) if1 ();

   // 0: NOR, 1: stuck-at-0, 2: AND, 3: stuck-at-1
   function automatic logic ymodel(input int m, input logic a, input logic b);
      case (m)
         0:       return ~(a | b);
         1:       return 1'b0;
         2:       return a & b;
         default: return 1'b1;
      endcase
   endfunction

   assign if0.dut_y = ymodel(mode0, if0.dut_a, if0.dut_b);
   assign if1.dut_y = ymodel(mode1, if1.dut_a, if1.dut_b);

   gate_response_checker #(.TRUTH(4'b0001), .SETTLE(2), .LOOPS(1), .ERRW(3)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.master)
   );

   gate_response_checker #(.TRUTH(4'b0001), .SETTLE(2), .LOOPS(4), .ERRW(2)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.master)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) if0.start = v;
      else           if1.start = v;
   endtask

   // Pulses start, then follows the run to the first idle cycle after done.
   task automatic run(input int inst, input bit agitate,
                      output int busy_n, output bit vec_ok, output int done_n);
      logic       b, d;
      logic [1:0] v;
      int         expv;
      busy_n = 0;
      done_n = 0;
      vec_ok = 1'b1;
      @(negedge clk);
      set_start(inst, 1'b1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         b = (inst == 0) ? if0.busy : if1.busy;
         d = (inst == 0) ? if0.done : if1.done;
         v = (inst == 0) ? {if0.dut_a, if0.dut_b} : {if1.dut_a, if1.dut_b};
         set_start(inst, agitate && b && i[0]);
         if (b) begin
            busy_n++;
            expv = ((busy_n - 1) / 3) % 4;
            if (v != 2'(expv)) vec_ok = 1'b0;
         end
         if (d) done_n++;
         if (done_n > 0 && !d) break;
      end
      set_start(inst, 1'b0);
   endtask

   int  bn, dn;
   bit  vok;
   bit  reached;
   logic any_busy;

   initial begin
      if0.start = 1'b0;
      if1.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ab",    {if0.dut_a, if0.dut_b}, 2'b00);
      check("rst_busy",  if0.busy, 1'b0);
      check("rst_done",  if0.done, 1'b0);
      check("rst_pass",  if0.pass, 1'b0);
      check("rst_err",   if0.err_cnt, 3'd0);
      check("rst_ff",    if0.first_fail, 2'b00);
      check("rst1_busy", if1.busy, 1'b0);

      // Correct NOR DUT
      mode0 = 0;
      run(0, 1'b0, bn, vok, dn);
      check("nor_busy",  bn, 12);
      check("nor_vec",   vok, 1'b1);
      check("nor_done",  dn, 1);
      check("nor_pass",  if0.pass, 1'b1);
      check("nor_err",   if0.err_cnt, 3'd0);
      check("nor_ff",    if0.first_fail, 2'b00);
      check("nor_hold",  {if0.dut_a, if0.dut_b}, 2'b11);
      check("nor_idle",  if0.busy, 1'b0);

      // Mid-cycle reset while idle with pass=1
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mrst_pass", if0.pass, 1'b0);
      check("mrst_ab",   {if0.dut_a, if0.dut_b}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      any_busy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         any_busy = any_busy | if0.busy | if0.done;
      end
      check("mrst_quiet", any_busy, 1'b0);
      check("mrst_err",   if0.err_cnt, 3'd0);

      // Stuck-at-0: only vector 00 mismatches
      mode0 = 1;
      run(0, 1'b0, bn, vok, dn);
      check("s0_err",  if0.err_cnt, 3'd1);
      check("s0_ff",   if0.first_fail, 2'b00);
      check("s0_pass", if0.pass, 1'b0);

      // AND gate: vectors 00 and 11 mismatch
      mode0 = 2;
      run(0, 1'b0, bn, vok, dn);
      check("and_err",  if0.err_cnt, 3'd2);
      check("and_ff",   if0.first_fail, 2'b00);
      check("and_pass", if0.pass, 1'b0);
      check("and_busy", bn, 12);

      // Stuck-at-1, LOOPS=4, ERRW=2: 12 mismatches saturate at 3
      mode1 = 3;
      run(1, 1'b0, bn, vok, dn);
      check("s1_busy", bn, 48);
      check("s1_vec",  vok, 1'b1);
      check("s1_done", dn, 1);
      check("s1_err",  if1.err_cnt, 2'd3);
      check("s1_ff",   if1.first_fail, 2'b01);
      check("s1_pass", if1.pass, 1'b0);

      // Start pulses while busy must not disturb the run
      mode0 = 0;
      run(0, 1'b1, bn, vok, dn);
      check("ag_busy", bn, 12);
      check("ag_vec",  vok, 1'b1);
      check("ag_done", dn, 1);
      check("ag_pass", if0.pass, 1'b1);
      repeat (3) @(negedge clk);
      check("ag_noq",  if0.busy, 1'b0);

      // Reset during vector 2 of a failing run
      mode0 = 1;
      @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if ({if0.dut_a, if0.dut_b} == 2'b10 && if0.busy) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("v2_reached", reached, 1'b1);
      check("v2_err_pre", if0.err_cnt, 3'd1);
      #2 rst = 1'b1;
      #1;
      check("v2_busy", if0.busy, 1'b0);
      check("v2_ab",   {if0.dut_a, if0.dut_b}, 2'b00);
      check("v2_err",  if0.err_cnt, 3'd0);
      check("v2_done", if0.done, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Clean run after the reset
      mode0 = 0;
      run(0, 1'b0, bn, vok, dn);
      check("cl_busy", bn, 12);
      check("cl_vec",  vok, 1'b1);
      check("cl_pass", if0.pass, 1'b1);
      check("cl_err",  if0.err_cnt, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Self-checking response sequencer for 2-input gate models. On `start` it drives every `{a,b}` combination into a device under test, waits a programmable settle time, samples the DUT output, and compares it against an expected truth table. It accumulates a saturating error count, records the first failing vector, and reports pass/fail. It sits opposite a gate DUT in benches and FPGA self-test harnesses, replacing hand-written stimulus blocks with a reusable checking end.

## Interface
- `TRUTH`, default 4'b0001: expected `y` per vector; bit index = `{a,b}` (default = NOR).
- `SETTLE`, default 2: wait cycles between applying a vector and sampling `dut_y`; legal range ≥1.
- `LOOPS`, default 1: number of full 4-vector sweeps per run; legal range ≥1.
- `ERRW`, default 3: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; accepted only in IDLE.
- `dut_a`  out  1  stimulus bit a (vector MSB).
- `dut_b`  out  1  stimulus bit b (vector LSB).
- `dut_y`  in  1  DUT response.
- `busy`  out  1  high from acceptance until the DONE cycle (exclusive).
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  1 when the last run had zero mismatches; held until the next accepted start.
- `err_cnt`  out  ERRW  mismatch count of the last or current run; saturates at 2^ERRW−1.
- `first_fail`  out  2  `{a,b}` of the first mismatch in the run; 2'b00 if none.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE + `start`=1 → WAIT. On that edge:
  - vector index ← 0 and loop counter ← 0;
  - `err_cnt` ← 0, `pass` ← 0, `first_fail` ← 0, first-fail flag cleared;
  - settle counter ← 0.
- WAIT: increment the settle counter. Move to SAMPLE when the counter reaches SETTLE−1.
- SAMPLE: compare `dut_y` with `TRUTH[{dut_a,dut_b}]`. On mismatch:
  - increment `err_cnt`, unless it is already saturated;
  - if this is the first mismatch, latch `first_fail` and set the flag.
- SAMPLE, after the compare, advances the vector:
  - vector < 3: index+1, → WAIT.
  - vector = 3 and loop < LOOPS−1: index wraps to 0, loop+1, → WAIT.
  - otherwise → DONE.
- DONE: `done`=1 and `busy`=0 for this one cycle. On this edge `pass` ← (`err_cnt`==0, including a mismatch counted on the final SAMPLE). → IDLE.
- `dut_a`/`dut_b` reflect the vector index continuously during WAIT and SAMPLE. They hold the last vector (2'b11) in DONE and IDLE until the next start.
- `start` is ignored in WAIT, SAMPLE and DONE. It does not queue.
- Saturation: once `err_cnt` = 2^ERRW−1 it holds. `pass` is still 0.

## Timing
- Reset values (asynchronous, effective immediately, including mid-run):
  - state IDLE, all counters 0;
  - `dut_a`=`dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail`=0.
- After reset deasserts, the next run needs a fresh `start`.
- Edge numbering: `start` is sampled at edge E0. `busy`=1 and vector 0 are driven from E0.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, then 1 in SAMPLE. `dut_y` is compared at the SAMPLE-ending edge, which is SETTLE+1 edges after the vector was applied.
- `done` is high in the cycle following edge E0 + 4·LOOPS·(SETTLE+1). `busy` is high for exactly 4·LOOPS·(SETTLE+1) cycles.
- The DUT path must settle within SETTLE cycles. Combinational DUTs are correct with any SETTLE ≥1.
- A new `start` can be accepted at the first IDLE cycle after DONE.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 immediately. Hold `start`=0 after release → outputs stay 0 and `busy`=0.
- Correct NOR DUT (`dut_y`=~(a|b)), defaults:
  - `start` pulse → `busy` high 12 cycles; vectors 00,01,10,11 each held 3 cycles;
  - `done` pulse; `pass`=1, `err_cnt`=0, `first_fail`=00.
- Stuck-at-0 DUT → `err_cnt`=1, `first_fail`=00, `pass`=0.
- AND-gate DUT → `err_cnt`=2 (vectors 00 and 11), `first_fail`=00, `pass`=0.
- Stuck-at-1 DUT, LOOPS=4, ERRW=2:
  - 12 mismatches → `err_cnt` saturates at 3, `first_fail`=01;
  - `done` after 48 busy cycles (SETTLE=2).
- Robustness, correct DUT:
  - pulse `start` repeatedly while `busy` → single run, identical timing;
  - assert `rst` during vector 2 → immediate reset values;
  - new `start` → full clean run with `pass`=1.
